// File: rtl/twiddle_mult_5_0.sv
// Complex twiddle multiplier: captures a coefficient table streamed in after reset, then
// multiplies each accepted sample by the next table entry through a 3-stage stall-able pipeline.
module twiddle_mult_5_0 #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned DW         = 16,
  parameter int unsigned CW         = 11,
  parameter int unsigned FRAC       = 9,
  parameter int unsigned LOAD_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*CW-1:0] coeff_in,
  output logic            loaded,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DW-1:0]   din_re,
  input  logic [DW-1:0]   din_im,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DW-1:0]   dout_re,
  output logic [DW-1:0]   dout_im,
  output logic            dout_last
);

  localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned LW = $clog2(LOAD_DELAY + SIZE + 1);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned SW = DW + CW + 1;

  localparam logic signed [SW-1:0] Half = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MaxV = {{(CW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = {{(CW + 2){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic {StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic            loaded_q, loaded_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2*CW-1:0] table_q [SIZE];
  logic            tbl_we;
  logic [IW-1:0]   tbl_waddr;

  logic            adv, accept;
  logic [2*CW-1:0] coef;

  logic                 v1_q, v1_d, last1_q, last1_d;
  logic signed [DW-1:0] dr1_q, dr1_d, di1_q, di1_d;
  logic signed [CW-1:0] cr1_q, cr1_d, ci1_q, ci1_d;

  logic                 v2_q, v2_d, last2_q, last2_d;
  logic signed [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;

  logic                 v3_q, v3_d, last3_q, last3_d;
  logic [DW-1:0]        re3_q, re3_d, im3_q, im3_d;

  // Round half up, arithmetic shift, then clamp to the signed output range.
  function automatic logic [DW-1:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = (x + Half) >>> FRAC;
    if (r > MaxV) begin
      return DW'(MaxV);
    end else if (r < MinV) begin
      return DW'(MinV);
    end
    return DW'(r);
  endfunction

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    loaded_d  = loaded_q;
    tbl_we    = 1'b0;
    tbl_waddr = IW'(lcnt_q - LW'(LOAD_DELAY));
    if (state_q == StLoad) begin
      lcnt_d = lcnt_q + LW'(1);
      if (lcnt_q >= LW'(LOAD_DELAY)) begin
        tbl_we = 1'b1;
      end
      if (lcnt_q == LW'(LOAD_DELAY + SIZE - 1)) begin
        state_d  = StRun;
        loaded_d = 1'b1;
      end
    end
  end

  always_comb begin
    adv       = !v3_q || dout_ready;
    din_ready = (state_q == StRun) && adv;
    accept    = din_valid && din_ready;
    coef      = table_q[idx_q];

    idx_d = idx_q;
    if (accept) begin
      idx_d = (idx_q == IW'(SIZE - 1)) ? '0 : idx_q + IW'(1);
    end

    v1_d = v1_q;  last1_d = last1_q;
    dr1_d = dr1_q; di1_d = di1_q; cr1_d = cr1_q; ci1_d = ci1_q;
    v2_d = v2_q;  last2_d = last2_q;
    prr_d = prr_q; pii_d = pii_q; pri_d = pri_q; pir_d = pir_q;
    v3_d = v3_q;  last3_d = last3_q;
    re3_d = re3_q; im3_d = im3_q;

    // Every stage moves together; a stalled output freezes the whole pipe.
    if (adv) begin
      v1_d    = accept;
      last1_d = (idx_q == IW'(SIZE - 1));
      dr1_d   = din_re;
      di1_d   = din_im;
      cr1_d   = coef[2*CW-1:CW];
      ci1_d   = coef[CW-1:0];

      v2_d    = v1_q;
      last2_d = last1_q;
      prr_d   = PW'(dr1_q) * PW'(cr1_q);
      pii_d   = PW'(di1_q) * PW'(ci1_q);
      pri_d   = PW'(dr1_q) * PW'(ci1_q);
      pir_d   = PW'(di1_q) * PW'(cr1_q);

      v3_d    = v2_q;
      last3_d = last2_q;
      re3_d   = round_sat(SW'(prr_q) - SW'(pii_q));
      im3_d   = round_sat(SW'(pri_q) + SW'(pir_q));
    end
  end

  // Table has no reset; every LOAD rewrites all entries.
  always_ff @(posedge clk) begin
    if (!rst && tbl_we) begin
      table_q[tbl_waddr] <= coeff_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      lcnt_q   <= '0;
      loaded_q <= 1'b0;
      idx_q    <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      dr1_q    <= '0;
      di1_q    <= '0;
      cr1_q    <= '0;
      ci1_q    <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      prr_q    <= '0;
      pii_q    <= '0;
      pri_q    <= '0;
      pir_q    <= '0;
      v3_q     <= 1'b0;
      last3_q  <= 1'b0;
      re3_q    <= '0;
      im3_q    <= '0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      dr1_q    <= dr1_d;
      di1_q    <= di1_d;
      cr1_q    <= cr1_d;
      ci1_q    <= ci1_d;
      v2_q     <= v2_d;
      last2_q  <= last2_d;
      prr_q    <= prr_d;
      pii_q    <= pii_d;
      pri_q    <= pri_d;
      pir_q    <= pir_d;
      v3_q     <= v3_d;
      last3_q  <= last3_d;
      re3_q    <= re3_d;
      im3_q    <= im3_d;
    end
  end

  assign loaded     = loaded_q;
  assign dout_valid = v3_q;
  assign dout_re    = re3_q;
  assign dout_im    = im3_q;
  assign dout_last  = last3_q;

endmodule
